// File: rtl/cbus_pkg.sv
// Shared CBus types for the multi-master crossbar: request/response bundles,
// burst encodings, crossbar FSM states and the address-window match helper.
package cbus_pkg;

  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  wstrobe;
    logic [63:0] wdata;
    logic [1:0]  burst;
    logic [7:0]  len;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] rdata;
  } cbus_resp_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_ERR  = 2'd2
  } xbar_state_t;

  function automatic logic addr_hit(input logic [63:0] addr,
                                    input logic [63:0] base,
                                    input logic [63:0] mask);
    return (addr & mask) == base;
  endfunction

endpackage

// File: rtl/cbus_rr_arbiter.sv
// Round-robin pick: first requester at or after rr_ptr, wrapping modulo N.
module cbus_rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] rr_ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] index
);

  logic          found_s;
  logic [IW:0]   cand_s;
  logic          take_s;

  // Walk the ring starting at rr_ptr and keep the first live requester.
  always_comb begin
    grant   = '0;
    index   = '0;
    found_s = 1'b0;
    cand_s  = '0;
    take_s  = 1'b0;
    for (int k = 0; k < N; k++) begin
      cand_s  = {1'b0, rr_ptr} + (IW+1)'(k);
      cand_s  = (cand_s >= (IW+1)'(N)) ? cand_s - (IW+1)'(N) : cand_s;
      take_s  = ~found_s & req[cand_s[IW-1:0]];
      grant[cand_s[IW-1:0]] = grant[cand_s[IW-1:0]] | take_s;
      index   = take_s ? cand_s[IW-1:0] : index;
      found_s = found_s | take_s;
    end
  end

endmodule

// File: rtl/cbus_xbar_mn.sv
// N-master / M-slave CBus crossbar: round-robin arbitration with burst lock,
// base/mask address routing and a built-in decode-error responder.
module cbus_xbar_mn
  import cbus_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int NUM_SLAVES  = 2,
  parameter logic [NUM_SLAVES-1:0][63:0] SLV_BASE = {64'h0000_0000_8000_0000, 64'h0},
  parameter logic [NUM_SLAVES-1:0][63:0] SLV_MASK = {64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_F000_0000}
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_MASTERS-1:0]            m_valid,
  input  logic [NUM_MASTERS-1:0][63:0]      m_addr,
  input  logic [NUM_MASTERS-1:0][2:0]       m_size,
  input  logic [NUM_MASTERS-1:0][7:0]       m_wstrobe,
  input  logic [NUM_MASTERS-1:0][63:0]      m_wdata,
  input  logic [NUM_MASTERS-1:0][1:0]       m_burst,
  input  logic [NUM_MASTERS-1:0][7:0]       m_len,
  output logic [NUM_MASTERS-1:0]            m_ready,
  output logic [NUM_MASTERS-1:0]            m_last,
  output logic [NUM_MASTERS-1:0][63:0]      m_rdata,
  output logic [NUM_SLAVES-1:0]             s_valid,
  output logic [NUM_SLAVES-1:0][63:0]       s_addr,
  output logic [NUM_SLAVES-1:0][2:0]        s_size,
  output logic [NUM_SLAVES-1:0][7:0]        s_wstrobe,
  output logic [NUM_SLAVES-1:0][63:0]       s_wdata,
  output logic [NUM_SLAVES-1:0][1:0]        s_burst,
  output logic [NUM_SLAVES-1:0][7:0]        s_len,
  input  logic [NUM_SLAVES-1:0]             s_ready,
  input  logic [NUM_SLAVES-1:0]             s_last,
  input  logic [NUM_SLAVES-1:0][63:0]       s_rdata,
  output logic                              decerr
);

  localparam int MW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  xbar_state_t     state_r, state_nxt_s;
  logic [MW-1:0]   rr_ptr_r, rr_ptr_nxt_s;
  logic [MW-1:0]   grant_r, grant_nxt_s;
  logic [SW-1:0]   target_r, target_nxt_s;
  logic [7:0]      beat_r, beat_nxt_s;

  logic [NUM_MASTERS-1:0] arb_onehot_s;
  logic [MW-1:0]          arb_idx_s;
  logic                   arb_any_s;
  logic [63:0]            cand_addr_s;
  logic                   dec_hit_s;
  logic [SW-1:0]          dec_idx_s;

  cbus_req_t   req_s [NUM_MASTERS];
  cbus_resp_t  resp_s [NUM_SLAVES];
  cbus_req_t   gnt_req_s;
  cbus_resp_t  tgt_resp_s;
  logic [MW-1:0] ptr_after_gnt_s;
  logic          gnt_last_beat_s;

  cbus_rr_arbiter #(
    .N  (NUM_MASTERS),
    .IW (MW)
  ) u_arb (
    .req    (m_valid),
    .rr_ptr (rr_ptr_r),
    .grant  (arb_onehot_s),
    .index  (arb_idx_s)
  );

  assign arb_any_s   = |arb_onehot_s;
  assign cand_addr_s = m_addr[arb_idx_s];

  // Bundle the flat port arrays into per-port request/response structs.
  always_comb begin
    for (int m = 0; m < NUM_MASTERS; m++) begin
      req_s[m] = '{valid:   m_valid[m],
                   addr:    m_addr[m],
                   size:    m_size[m],
                   wstrobe: m_wstrobe[m],
                   wdata:   m_wdata[m],
                   burst:   m_burst[m],
                   len:     m_len[m]};
    end
    for (int s = 0; s < NUM_SLAVES; s++) begin
      resp_s[s] = '{ready: s_ready[s], last: s_last[s], rdata: s_rdata[s]};
    end
  end

  // Window decode of the arbitration winner; scanning downward lets the lowest index win overlaps.
  always_comb begin
    dec_hit_s = 1'b0;
    dec_idx_s = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      dec_idx_s = addr_hit(cand_addr_s, SLV_BASE[i], SLV_MASK[i]) ? SW'(i) : dec_idx_s;
      dec_hit_s = dec_hit_s | addr_hit(cand_addr_s, SLV_BASE[i], SLV_MASK[i]);
    end
  end

  assign gnt_req_s       = req_s[grant_r];
  assign tgt_resp_s      = resp_s[target_r];
  assign ptr_after_gnt_s = (grant_r == MW'(NUM_MASTERS - 1)) ? '0 : grant_r + MW'(1);
  assign gnt_last_beat_s = (beat_r == gnt_req_s.len);

  // Next-state logic; an abort (granted valid dropping) leaves rr_ptr untouched.
  always_comb begin
    state_nxt_s  = state_r;
    rr_ptr_nxt_s = rr_ptr_r;
    grant_nxt_s  = grant_r;
    target_nxt_s = target_r;
    beat_nxt_s   = beat_r;
    case (state_r)
      ST_IDLE: begin
        if (arb_any_s) begin
          grant_nxt_s  = arb_idx_s;
          target_nxt_s = dec_idx_s;
          beat_nxt_s   = 8'd0;
          state_nxt_s  = dec_hit_s ? ST_BUSY : ST_ERR;
        end else begin
          state_nxt_s  = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (!gnt_req_s.valid) begin
          state_nxt_s  = ST_IDLE;
        end else if (tgt_resp_s.ready && tgt_resp_s.last) begin
          rr_ptr_nxt_s = ptr_after_gnt_s;
          state_nxt_s  = ST_IDLE;
        end else begin
          state_nxt_s  = ST_BUSY;
        end
      end
      ST_ERR: begin
        if (!gnt_req_s.valid) begin
          state_nxt_s  = ST_IDLE;
        end else if (gnt_last_beat_s) begin
          rr_ptr_nxt_s = ptr_after_gnt_s;
          state_nxt_s  = ST_IDLE;
        end else begin
          beat_nxt_s   = beat_r + 8'd1;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, pointer and grant registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      rr_ptr_r <= '0;
      grant_r  <= '0;
      target_r <= '0;
      beat_r   <= 8'd0;
    end else begin
      state_r  <= state_nxt_s;
      rr_ptr_r <= rr_ptr_nxt_s;
      grant_r  <= grant_nxt_s;
      target_r <= target_nxt_s;
      beat_r   <= beat_nxt_s;
    end
  end

  // Output routing: passthrough in BUSY, local responder in ERR, silent otherwise.
  always_comb begin
    m_ready   = '0;
    m_last    = '0;
    m_rdata   = '0;
    s_valid   = '0;
    s_addr    = '0;
    s_size    = '0;
    s_wstrobe = '0;
    s_wdata   = '0;
    s_burst   = '0;
    s_len     = '0;
    decerr    = 1'b0;
    case (state_r)
      ST_BUSY: begin
        s_valid[target_r]   = gnt_req_s.valid;
        s_addr[target_r]    = gnt_req_s.addr;
        s_size[target_r]    = gnt_req_s.size;
        s_wstrobe[target_r] = gnt_req_s.wstrobe;
        s_wdata[target_r]   = gnt_req_s.wdata;
        s_burst[target_r]   = gnt_req_s.burst;
        s_len[target_r]     = gnt_req_s.len;
        m_ready[grant_r]    = tgt_resp_s.ready;
        m_last[grant_r]     = tgt_resp_s.last;
        m_rdata[grant_r]    = tgt_resp_s.rdata;
      end
      ST_ERR: begin
        m_ready[grant_r] = gnt_req_s.valid;
        m_last[grant_r]  = gnt_req_s.valid & gnt_last_beat_s;
        decerr           = gnt_req_s.valid & gnt_last_beat_s;
      end
      default: begin
        decerr = 1'b0;
      end
    endcase
  end

endmodule
